// File: rtl/axi_led_pwm_ctrl_if.sv
// rtl/axi_led_pwm_ctrl_if.sv - AXI4-Lite bus bundle for the LED PWM controller
//
// Purpose: groups the five AXI4-Lite channels (AW, W, B, AR, R) so the
// controller and its master connect through a single port.
// Ports (per modport):
//   slave  : receives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready,
//            araddr/arprot/arvalid, rready; drives awready, wready,
//            bresp/bvalid, arready, rdata/rresp/rvalid.
//   master : the mirror image of slave.
interface axi_led_pwm_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_led_pwm_ctrl.sv
// rtl/axi_led_pwm_ctrl.sv - AXI4-Lite LED controller with PWM brightness and blink
//
// Purpose: drives NUM_LEDS outputs from a static pattern register, gated by a
// free-running PWM comparator and an optional blink phase. Eight word
// registers: CTRL, LED_VAL, DUTY, BLINK_DIV, STATUS (ro), three reserved.
// Ports:
//   s00_axi_aclk    : clock
//   s00_axi_aresetn : asynchronous active-low reset
//   s00_axi         : AXI4-Lite slave (axi_led_pwm_ctrl_if.slave)
//   led_o           : registered LED drive
module axi_led_pwm_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_LEDS           = 4,
    parameter int PWM_WIDTH          = 8,
    parameter int BLINK_WIDTH        = 24
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    axi_led_pwm_ctrl_if.slave       s00_axi,
    output logic [NUM_LEDS-1:0]     led_o
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_LED_VAL   = 3'd1;
    localparam logic [2:0] REG_DUTY      = 3'd2;
    localparam logic [2:0] REG_BLINK_DIV = 3'd3;
    localparam logic [2:0] REG_STATUS    = 3'd4;

    // AW and W are only ever accepted together, so one flop drives both readies.
    logic                   aw_w_ready_q, aw_w_ready_d;
    logic                   bvalid_q,     bvalid_d;
    logic                   arready_q,    arready_d;
    logic                   rvalid_q,     rvalid_d;
    logic [DW-1:0]          rdata_q,      rdata_d;
    logic [1:0]             ctrl_q,       ctrl_d;
    logic [NUM_LEDS-1:0]    led_val_q,    led_val_d;
    logic [PWM_WIDTH-1:0]   duty_q,       duty_d;
    logic [BLINK_WIDTH-1:0] blink_div_q,  blink_div_d;
    logic [PWM_WIDTH-1:0]   pwm_cnt_q,    pwm_cnt_d;
    logic [BLINK_WIDTH-1:0] blink_cnt_q,  blink_cnt_d;
    logic                   phase_q,      phase_d;
    logic [NUM_LEDS-1:0]    led_q,        led_d;

    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]                    wr_word;
    logic [2:0]                    rd_word;
    logic                          wr_fire;
    logic                          rd_fire;
    logic                          pwm_on;
    logic [DW-1:0]                 status;
    logic [DW-1:0]                 rd_mux;
    logic                          unused_ok;

    assign aw_addr = s00_axi.awaddr;
    assign ar_addr = s00_axi.araddr;
    assign wr_word = aw_addr[4:2];
    assign rd_word = ar_addr[4:2];

    // Byte lanes and protection bits carry no meaning for word registers.
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, aw_addr[1:0], ar_addr[1:0]};

    function automatic logic [DW-1:0] strb_merge(
        input logic [DW-1:0]     old_val,
        input logic [DW-1:0]     new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        aw_w_ready_d = 1'b0;
        bvalid_d     = bvalid_q;
        arready_d    = 1'b0;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        ctrl_d       = ctrl_q;
        led_val_d    = led_val_q;
        duty_d       = duty_q;
        blink_div_d  = blink_div_q;
        pwm_cnt_d    = pwm_cnt_q + PWM_WIDTH'(1);
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        led_d        = '0;

        // The master must hold valid while ready is high, so the handshake
        // edge is simply the edge on which our registered ready is seen.
        wr_fire = aw_w_ready_q & s00_axi.awvalid & s00_axi.wvalid;
        rd_fire = arready_q & s00_axi.arvalid;

        // Ready is a one-cycle pulse: it is withheld on the cycle after it
        // fired, so a held valid cannot be double-accepted.
        aw_w_ready_d = s00_axi.awvalid & s00_axi.wvalid & ~bvalid_q & ~aw_w_ready_q;
        arready_d    = s00_axi.arvalid & ~rvalid_q & ~arready_q;

        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s00_axi.bready) begin
            bvalid_d = 1'b0;
        end

        status                 = '0;
        status[0]              = phase_q;
        status[PWM_WIDTH+7:8]  = pwm_cnt_q;

        case (rd_word)
            REG_CTRL:      rd_mux = DW'(ctrl_q);
            REG_LED_VAL:   rd_mux = DW'(led_val_q);
            REG_DUTY:      rd_mux = DW'(duty_q);
            REG_BLINK_DIV: rd_mux = DW'(blink_div_q);
            REG_STATUS:    rd_mux = status;
            default:       rd_mux = '0;
        endcase

        // Read data is sampled from the pre-edge register values, so a
        // read colliding with a write to the same register returns the old one.
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && s00_axi.rready) begin
            rvalid_d = 1'b0;
        end

        if (wr_fire) begin
            case (wr_word)
                REG_CTRL:      ctrl_d      = 2'(strb_merge(DW'(ctrl_q), s00_axi.wdata, s00_axi.wstrb));
                REG_LED_VAL:   led_val_d   = NUM_LEDS'(strb_merge(DW'(led_val_q), s00_axi.wdata, s00_axi.wstrb));
                REG_DUTY:      duty_d      = PWM_WIDTH'(strb_merge(DW'(duty_q), s00_axi.wdata, s00_axi.wstrb));
                REG_BLINK_DIV: blink_div_d = BLINK_WIDTH'(strb_merge(DW'(blink_div_q), s00_axi.wdata, s00_axi.wstrb));
                default:       ;
            endcase
        end

        // Blink: disabled parks the phase high so LEDs follow PWM alone; a new
        // divider restarts the half-period without disturbing the phase.
        if (!ctrl_q[1]) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (wr_fire && wr_word == REG_BLINK_DIV) begin
            blink_cnt_d = '0;
        end else if (blink_cnt_q == blink_div_q) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_WIDTH'(1);
        end

        pwm_on = (pwm_cnt_q < duty_q);
        if (ctrl_q[0]) begin
            led_d = led_val_q & {NUM_LEDS{pwm_on & phase_q}};
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_w_ready_q <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            ctrl_q       <= '0;
            led_val_q    <= '0;
            duty_q       <= '0;
            blink_div_q  <= '0;
            pwm_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            led_q        <= '0;
        end else begin
            aw_w_ready_q <= aw_w_ready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            ctrl_q       <= ctrl_d;
            led_val_q    <= led_val_d;
            duty_q       <= duty_d;
            blink_div_q  <= blink_div_d;
            pwm_cnt_q    <= pwm_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            led_q        <= led_d;
        end
    end

    assign s00_axi.awready = aw_w_ready_q;
    assign s00_axi.wready  = aw_w_ready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;
    assign led_o           = led_q;
endmodule

// File: tb/tb_axi_led_pwm_ctrl.sv
// tb/tb_axi_led_pwm_ctrl.sv - self-checking bench for axi_led_pwm_ctrl
module tb_axi_led_pwm_ctrl;
    localparam int NL = 4;
    localparam int PW = 8;
    localparam int BW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_led_pwm_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
    logic [NL-1:0] led;

    axi_led_pwm_ctrl #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_LEDS(NL),
        .PWM_WIDTH(PW),
        .BLINK_WIDTH(BW)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi(bus),
        .led_o(led)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_cyc   = 0;
    logic [1:0]    m_ctrl  = '0;
    logic [NL-1:0] m_led   = '0;
    logic [PW-1:0] m_duty  = '0;
    logic [BW-1:0] m_div   = '0;
    int            m_bcnt  = 0;
    logic          m_phase = 1'b1;
    logic [NL-1:0] exp_led = '0;

    logic          pend_write = 1'b0;
    logic [4:0]    pend_addr  = '0;
    logic [31:0]   pend_data  = '0;
    logic [3:0]    pend_strb  = '0;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return 32'(m_ctrl);
            3'd1:    return 32'(m_led);
            3'd2:    return 32'(m_duty);
            3'd3:    return 32'(m_div);
            3'd4:    return 32'((m_cyc % (1 << PW)) * 256 + int'(m_phase));
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cyc = 0; m_ctrl = '0; m_led = '0; m_duty = '0; m_div = '0;
                m_bcnt = 0; m_phase = 1'b1; exp_led = '0;
            end else begin
                logic on;
                logic div_wr;
                on = (m_cyc % (1 << PW)) < int'(m_duty);
                exp_led = m_ctrl[0] ? (m_led & {NL{on && m_phase}}) : '0;
                div_wr = pend_write && (pend_addr[4:2] == 3'd3);
                if (!m_ctrl[1]) begin
                    m_bcnt = 0; m_phase = 1'b1;
                end else if (div_wr) begin
                    m_bcnt = 0;
                end else if (m_bcnt == int'(m_div)) begin
                    m_bcnt = 0; m_phase = !m_phase;
                end else begin
                    m_bcnt++;
                end
                if (pend_write) begin
                    case (pend_addr[4:2])
                        3'd0: m_ctrl = 2'(merge(32'(m_ctrl), pend_data, pend_strb));
                        3'd1: m_led  = NL'(merge(32'(m_led), pend_data, pend_strb));
                        3'd2: m_duty = PW'(merge(32'(m_duty), pend_data, pend_strb));
                        3'd3: m_div  = BW'(merge(32'(m_div), pend_data, pend_strb));
                        default: ;
                    endcase
                end
                m_cyc++;
            end
        end
    end

    // Every-cycle comparison of the LED drive against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("led_o", 32'(led), 32'(exp_led));
        end
    end

    // ---------------- bus tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
        @(posedge clk); @(negedge clk);
        chk("awready", 32'(bus.awready), 32'd1);
        chk("wready", 32'(bus.wready), 32'd1);
        pend_addr = a; pend_data = d; pend_strb = s; pend_write = 1'b1;
        @(posedge clk); @(negedge clk);
        pend_write = 1'b0;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bvalid", 32'(bus.bvalid), 32'd1);
        chk("bresp", 32'(bus.bresp), 32'd0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        logic [31:0] e;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = a;
        @(posedge clk); @(negedge clk);
        chk("arready", 32'(bus.arready), 32'd1);
        e = model_rd(a);
        @(posedge clk); @(negedge clk);
        bus.arvalid = 1'b0;
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        chk("rresp", 32'(bus.rresp), 32'd0);
        chk($sformatf("rdata@%02h", a), bus.rdata, e);
        d = bus.rdata;
    endtask

    // ---------------- directed test ----------------
    initial begin
        logic [31:0] d;
        int cnt;
        int tog;
        logic last_ph;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Reset
        #195;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        rd(5'h00, d); chk("rst_ctrl", d, 32'h0);
        rd(5'h04, d); chk("rst_led_val", d, 32'h0);
        rd(5'h08, d); chk("rst_duty", d, 32'h0);
        rd(5'h0C, d); chk("rst_blink_div", d, 32'h0);
        rd(5'h10, d); chk("rst_status_phase", d & 32'hFFFF00FF, 32'h1);

        // Sequential write/readback
        wr(5'h00, 32'h1, 4'hF);
        wr(5'h04, 32'h2, 4'hF);
        wr(5'h08, 32'h3, 4'hF);
        wr(5'h0C, 32'h4, 4'hF);
        rd(5'h00, d); chk("seq_ctrl", d, 32'h1);
        rd(5'h04, d); chk("seq_led_val", d, 32'h2);
        rd(5'h08, d); chk("seq_duty", d, 32'h3);
        rd(5'h0C, d); chk("seq_blink_div", d, 32'h4);
        wr(5'h14, 32'hFFFFFFFF, 4'hF);
        wr(5'h10, 32'hFFFFFFFF, 4'hF);
        rd(5'h14, d); chk("unmapped_14", d, 32'h0);
        rd(5'h1C, d); chk("unmapped_1c", d, 32'h0);
        wr(5'h00, 32'hFFFFFFFF, 4'hF);
        rd(5'h00, d); chk("ctrl_unimpl_bits", d, 32'h3);
        wr(5'h00, 32'h1, 4'hF);

        // WSTRB
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h0C, 32'hAABBCCDD, 4'b0010);
        rd(5'h0C, d); chk("wstrb_blink_div", d, 32'h0000CC00);

        // PWM duty counts over one full period
        wr(5'h04, 32'hF, 4'hF);
        wr(5'h08, 32'd64, 4'hF);
        cyc(2);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led == 4'hF) cnt++;
        end
        chk("pwm_duty64_on", 32'(cnt), 32'd64);
        wr(5'h08, 32'd0, 4'hF);
        cyc(2);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led != 4'h0) cnt++;
        end
        chk("pwm_duty0_on", 32'(cnt), 32'd0);
        wr(5'h08, 32'd255, 4'hF);
        cyc(2);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led == 4'hF) cnt++;
        end
        chk("pwm_duty255_on", 32'(cnt), 32'd255);

        // Blink: half-period of 4 cycles
        wr(5'h0C, 32'd3, 4'hF);
        wr(5'h00, 32'h3, 4'hF);
        cyc(3);
        tog = 0;
        last_ph = m_phase;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_phase != last_ph) tog++;
            last_ph = m_phase;
        end
        chk("model_blink_toggles", 32'(tog), 32'd10);
        wr(5'h0C, 32'd5, 4'hF);
        cyc(17);
        wr(5'h00, 32'h1, 4'hF);
        cyc(1);
        chk("model_phase_off", 32'(m_phase), 32'd1);
        rd(5'h10, d); chk("status_phase_off", 32'(d[0]), 32'd1);

        // AW presented 5 cycles before W
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 5'h04;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("aw_alone_awready", 32'(bus.awready), 32'd0);
            chk("aw_alone_wready", 32'(bus.wready), 32'd0);
        end
        bus.wvalid = 1'b1; bus.wdata = 32'h6; bus.wstrb = 4'hF;
        @(posedge clk); @(negedge clk);
        chk("aw_w_awready", 32'(bus.awready), 32'd1);
        pend_addr = 5'h04; pend_data = 32'h6; pend_strb = 4'hF; pend_write = 1'b1;
        @(posedge clk); @(negedge clk);
        pend_write = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("aw_w_bvalid", 32'(bus.bvalid), 32'd1);
        rd(5'h04, d); chk("aw_lead_led_val", d, 32'h6);

        // bready held low: bvalid stays, next write blocked
        @(negedge clk); bus.bready = 1'b0;
        wr(5'h04, 32'h9, 4'hF);
        bus.awvalid = 1'b1; bus.awaddr = 5'h08;
        bus.wvalid = 1'b1; bus.wdata = 32'h20; bus.wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bhold_bvalid", 32'(bus.bvalid), 32'd1);
            chk("bhold_awready", 32'(bus.awready), 32'd0);
        end
        bus.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bhold_bvalid_drop", 32'(bus.bvalid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("bhold_second_awready", 32'(bus.awready), 32'd1);
        pend_addr = 5'h08; pend_data = 32'h20; pend_strb = 4'hF; pend_write = 1'b1;
        @(posedge clk); @(negedge clk);
        pend_write = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bhold_second_bvalid", 32'(bus.bvalid), 32'd1);
        rd(5'h08, d); chk("bhold_duty", d, 32'h20);

        // Read and write to the same register on the same edge
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 5'h04;
        bus.wvalid = 1'b1; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 5'h04;
        @(posedge clk); @(negedge clk);
        chk("coll_awready", 32'(bus.awready), 32'd1);
        chk("coll_arready", 32'(bus.arready), 32'd1);
        pend_addr = 5'h04; pend_data = 32'h5; pend_strb = 4'hF; pend_write = 1'b1;
        @(posedge clk); @(negedge clk);
        pend_write = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("coll_rvalid", 32'(bus.rvalid), 32'd1);
        chk("coll_old_value", bus.rdata, 32'h9);
        rd(5'h04, d); chk("coll_new_value", d, 32'h5);

        // Reset while rvalid is pending
        @(negedge clk); bus.rready = 1'b0;
        rd(5'h00, d);
        cyc(3);
        chk("rhold_rvalid", 32'(bus.rvalid), 32'd1);
        chk("rhold_rdata", bus.rdata, 32'h1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_mid_led", 32'(led), 32'd0);
        bus.rready = 1'b1;
        cyc(20);
        rst_n = 1'b1;
        rd(5'h00, d); chk("post_rst_ctrl", d, 32'h0);
        rd(5'h08, d); chk("post_rst_duty", d, 32'h0);

        cyc(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
